// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - FSM state encoding
//   - default geometry (base byte address, depth in words)
//   - addr_legal(): alignment and range check for a byte address
package data_mem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned DEFAULT_BASE_ADDR   = 1024;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 64;

  // A word access is legal when it is word aligned, not below the base,
  // and its word index falls inside the array.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
    logic [31:0] offset;
    offset = addr - base;
    return (addr[1:0] == 2'b00) && (addr >= base) && ({2'b00, offset[31:2]} < depth);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port 32-bit word array with clear-on-reset.
// Ports:
//   clk, rst_n      clock, async active-low reset (clears every word and rd_data)
//   wr_en, wr_data  write wr_data into mem[index] on the rising edge
//   rd_en           load rd_data from mem[index] on the rising edge
//   rd_clr          force rd_data to 0 (has priority over rd_en)
//   index           word index
//   rd_data         registered read data, held between loads
module data_mem_array #(
  parameter int DEPTH_WORDS = 64,
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic          rd_clr,
  input  logic [IW-1:0] index,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[index] <= wr_data;
      if (rd_clr)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[index];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder serving MEM-stage read/write requests after a
// configurable latency.
// Ports:
//   clk, rst        clock, async active-low reset
//   MEM_R_EN/W_EN   read / write request
//   Address         byte address
//   ST_val          store data
//   MEM_read_value  read data, valid with Ready, then held
//   Ready           one-cycle completion pulse
//   Stall           combinational pipeline freeze request
//   Addr_error      with Ready when the completed access was illegal
//
// state | meaning
// IDLE  | no access in flight; a request is accepted on the next edge
// WAIT  | request latched; counting down the latency
// DONE  | access performed; Ready pulse, inputs ignored
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'(DEFAULT_BASE_ADDR),
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] Address,
  input  logic [31:0] ST_val,
  output logic [31:0] MEM_read_value,
  output logic        Ready,
  output logic        Stall,
  output logic        Addr_error
);

  localparam logic [3:0] CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] addr_q, data_q;
  logic        rd_q, wr_q, err_q;

  logic        req, access, acc_rd, acc_wr, acc_ok;
  logic [31:0] acc_addr, acc_data, acc_offset;
  logic [IW-1:0] acc_index;

  // With zero latency the access happens on the accepting edge, so it must
  // use the live inputs; otherwise it uses the latched request.
  always_comb begin
    req        = MEM_R_EN | MEM_W_EN;
    access     = ((state == ST_IDLE) && req && (LATENCY == 0)) ||
                 ((state == ST_WAIT) && (cnt == 4'd0));
    acc_addr   = (state == ST_IDLE) ? Address  : addr_q;
    acc_data   = (state == ST_IDLE) ? ST_val   : data_q;
    acc_rd     = (state == ST_IDLE) ? MEM_R_EN : rd_q;
    acc_wr     = (state == ST_IDLE) ? MEM_W_EN : wr_q;
    acc_ok     = addr_legal(acc_addr, BASE_ADDR, 32'(DEPTH_WORDS)) && (acc_rd ^ acc_wr);
    acc_offset = acc_addr - BASE_ADDR;
    acc_index  = IW'(acc_offset >> 2);
  end

  data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (access & acc_ok & acc_wr),
    .rd_en   (access & acc_ok & acc_rd),
    .rd_clr  (access & ~acc_ok),
    .index   (acc_index),
    .wr_data (acc_data),
    .rd_data (MEM_read_value)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q <= Address;
            data_q <= ST_val;
            rd_q   <= MEM_R_EN;
            wr_q   <= MEM_W_EN;
            if (LATENCY == 0) begin
              err_q <= ~acc_ok;
              state <= ST_DONE;
            end else begin
              cnt   <= CNT_LOAD;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            err_q <= ~acc_ok;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Ready      = (state == ST_DONE);
  assign Addr_error = Ready & err_q;
  assign Stall      = ((state == ST_IDLE) & req) | (state == ST_WAIT);

endmodule
